preamble_frame_controller: RTL and testbench

- Sequences frame capture after the preamble detector fires.
- Watches the detector's trigger alongside the same AXIS sample stream, waits a programmable alignment offset, then forwards a programmable number of payload samples into an output FIFO as one AXIS frame with tlast.
- Enforces a holdoff before re-arming.
- Sits between the preamble detector/demodulator and the downstream symbol/bit processing.

---
 rtl/preamble_frame_controller.sv | 190 +++++++++++++++++++
 tb/tb_preamble_frame_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/preamble_frame_controller.sv
// rtl/preamble_frame_controller.sv - trigger-aligned frame capture into an AXIS output FIFO
module preamble_frame_controller #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH             = 16,
    parameter int LEN_WIDTH              = 16
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic                              s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    output logic                              s00_axis_tready,
    input  logic                              trigger,
    input  logic                              enable,
    input  logic [LEN_WIDTH-1:0]              align_offset,
    input  logic [LEN_WIDTH-1:0]              payload_len,
    input  logic [LEN_WIDTH-1:0]              holdoff_len,
    output logic                              m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                              m00_axis_tlast,
    input  logic                              m00_axis_tready,
    output logic                              busy,
    output logic [2:0]                        state,
    output logic [31:0]                       frame_count,
    output logic [31:0]                       drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = C_S00_AXIS_TDATA_WIDTH;
    localparam logic [AW:0]          CNT_NONFINAL = (AW+1)'(FIFO_DEPTH - 2);
    localparam logic [AW:0]          CNT_FINAL    = (AW+1)'(FIFO_DEPTH - 1);
    localparam logic [AW:0]          CNT_ONE      = (AW+1)'(1);
    localparam logic [AW-1:0]        PTR_ONE      = AW'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE      = LEN_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_ALIGN   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] off_q, off_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] hold_q, hold_d;
    logic [31:0]          frame_cnt_q, frame_cnt_d;
    logic [31:0]          drop_cnt_q, drop_cnt_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          fill_q, fill_d;
    logic [DW:0]          mem [FIFO_DEPTH];

    logic                 beat;
    logic                 cap_final;
    logic                 push;
    logic                 pop;
    logic [LEN_WIDTH-1:0] len_last;
    logic [DW:0]          head;

    assign beat     = s00_axis_tvalid;
    // A zero length is treated as a one-beat frame.
    assign len_last = (len_q == '0) ? '0 : len_q - LEN_ONE;
    assign pop      = m00_axis_tvalid && m00_axis_tready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        len_d       = len_q;
        hold_d      = hold_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        push        = 1'b0;
        cap_final   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (beat && trigger) begin
                    off_d   = align_offset;
                    len_d   = payload_len;
                    hold_d  = holdoff_len;
                    cnt_d   = '0;
                    state_d = (align_offset != '0) ? ST_ALIGN : ST_CAPTURE;
                end
            end
            ST_ALIGN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (beat) begin
                    if (cnt_q == off_q - LEN_ONE) begin
                        cnt_d   = '0;
                        state_d = ST_CAPTURE;
                    end else begin
                        cnt_d = cnt_q + LEN_ONE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (beat) begin
                    cap_final = (cnt_q == len_last);
                    // Non-final beats leave one slot free so the tlast beat always fits.
                    if (cap_final ? (fill_q <= CNT_FINAL) : (fill_q <= CNT_NONFINAL)) begin
                        push = 1'b1;
                    end else begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end
                    if (cap_final) begin
                        frame_cnt_d = frame_cnt_q + 32'd1;
                        cnt_d       = '0;
                        if (hold_q != '0)  state_d = ST_HOLDOFF;
                        else if (enable)   state_d = ST_SEARCH;
                        else               state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + LEN_ONE;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (beat) begin
                    if (cnt_q == hold_q - LEN_ONE) begin
                        cnt_d   = '0;
                        state_d = ST_SEARCH;
                    end else begin
                        cnt_d = cnt_q + LEN_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        fill_d   = fill_q;
        if (push && !pop)      fill_d = fill_q + CNT_ONE;
        else if (!push && pop) fill_d = fill_q - CNT_ONE;
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            off_q       <= '0;
            len_q       <= '0;
            hold_q      <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            len_q       <= len_d;
            hold_q      <= hold_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (push) mem[wr_ptr_q] <= {cap_final, s00_axis_tdata};
    end

    // Output is forced to zero when empty so reset and idle read back clean.
    assign head            = mem[rd_ptr_q];
    assign m00_axis_tvalid = (fill_q != '0);
    assign m00_axis_tdata  = m00_axis_tvalid ? head[DW-1:0] : '0;
    assign m00_axis_tlast  = m00_axis_tvalid && head[DW];
    assign s00_axis_tready = 1'b1;
    assign busy            = (state_q == ST_ALIGN) || (state_q == ST_CAPTURE);
    assign state           = state_q;
    assign frame_count     = frame_cnt_q;
    assign drop_count      = drop_cnt_q;

endmodule

// File: tb/tb_preamble_frame_controller.sv
// tb/tb_preamble_frame_controller.sv - randomized and directed bench for preamble_frame_controller
module tb_preamble_frame_controller;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int LW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          s00_axis_tvalid = 1'b0;
    logic [DW-1:0] s00_axis_tdata = '0;
    logic          s00_axis_tready;
    logic          trigger = 1'b0;
    logic          enable = 1'b0;
    logic [LW-1:0] align_offset = '0;
    logic [LW-1:0] payload_len = '0;
    logic [LW-1:0] holdoff_len = '0;
    logic          m00_axis_tvalid;
    logic [DW-1:0] m00_axis_tdata;
    logic          m00_axis_tlast;
    logic          m00_axis_tready = 1'b0;
    logic          busy;
    logic [2:0]    state;
    logic [31:0]   frame_count;
    logic [31:0]   drop_count;

    always #5 clk = ~clk;

    preamble_frame_controller #(
        .C_S00_AXIS_TDATA_WIDTH(DW),
        .C_M00_AXIS_TDATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .LEN_WIDTH(LW)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid (s00_axis_tvalid),
        .s00_axis_tdata  (s00_axis_tdata),
        .s00_axis_tready (s00_axis_tready),
        .trigger         (trigger),
        .enable          (enable),
        .align_offset    (align_offset),
        .payload_len     (payload_len),
        .holdoff_len     (holdoff_len),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tlast  (m00_axis_tlast),
        .m00_axis_tready (m00_axis_tready),
        .busy            (busy),
        .state           (state),
        .frame_count     (frame_count),
        .drop_count      (drop_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase number, beats left in the phase, queue for the FIFO.
    int          m_state = 0;
    int          m_left = 0;
    int          l_len = 0;
    int          l_hold = 0;
    bit [31:0]   m_fc = 0;
    bit [31:0]   m_dc = 0;
    bit [32:0]   mq[$];
    bit [32:0]   obs[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_left  = 0;
        m_fc    = 0;
        m_dc    = 0;
        mq.delete();
    endtask

    task automatic model_step(input bit en, input bit tv, input bit trig, input bit [31:0] d, input bit rdy);
        int occ;
        bit pop;
        bit push;
        bit last;
        occ  = mq.size();
        pop  = (occ > 0) && rdy;
        push = 1'b0;
        last = 1'b0;
        case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) m_state = 0;
               else if (tv && trig) begin
                   l_len  = (payload_len == 0) ? 1 : int'(payload_len);
                   l_hold = int'(holdoff_len);
                   if (align_offset > 0) begin m_state = 2; m_left = int'(align_offset); end
                   else begin m_state = 3; m_left = l_len; end
               end
            2: if (!en) m_state = 0;
               else if (tv) begin
                   m_left--;
                   if (m_left == 0) begin m_state = 3; m_left = l_len; end
               end
            3: if (tv) begin
                   m_left--;
                   last = (m_left == 0);
                   if (occ < (last ? DEPTH : DEPTH - 1)) push = 1'b1;
                   else m_dc++;
                   if (last) begin
                       m_fc++;
                       if (l_hold > 0) begin m_state = 4; m_left = l_hold; end
                       else m_state = en ? 1 : 0;
                   end
               end
            4: if (!en) m_state = 0;
               else if (tv) begin
                   m_left--;
                   if (m_left == 0) m_state = 1;
               end
            default: m_state = 0;
        endcase
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back({last, d});
    endtask

    task automatic compare_all();
        check_eq("state", state, m_state);
        check_eq("busy", busy, (m_state == 2) || (m_state == 3));
        check_eq("tvalid", m00_axis_tvalid, mq.size() > 0);
        if (mq.size() > 0) begin
            check_eq("tdata", m00_axis_tdata, mq[0][31:0]);
            check_eq("tlast", m00_axis_tlast, mq[0][32]);
        end
        check_eq("frame_count", frame_count, m_fc);
        check_eq("drop_count", drop_count, m_dc);
    endtask

    task automatic cycle(input bit en, input bit tv, input bit trig, input bit [31:0] d, input bit rdy);
        enable          = en;
        s00_axis_tvalid = tv;
        trigger         = trig;
        s00_axis_tdata  = d;
        m00_axis_tready = rdy;
        #1;
        if (m00_axis_tvalid && rdy) obs.push_back({m00_axis_tlast, m00_axis_tdata});
        @(posedge clk);
        model_step(en, tv, trig, d, rdy);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_tvalid", m00_axis_tvalid, 1'b0);
        check_eq("rst_tlast", m00_axis_tlast, 1'b0);
        check_eq("rst_tdata", m00_axis_tdata, 32'd0);
        check_eq("rst_state", state, 3'd0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_frame_count", frame_count, 32'd0);
        check_eq("rst_drop_count", drop_count, 32'd0);
        model_reset();
        enable          = 1'b0;
        s00_axis_tvalid = 1'b0;
        trigger         = 1'b0;
        m00_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int rp;
        @(posedge clk);
        #1;
        do_reset();

        // Basic frame: offset 2, length 4, trigger on the beat carrying 12.
        align_offset = 2; payload_len = 4; holdoff_len = 0;
        obs.delete();
        cycle(1, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) cycle(1, 1, (10 + i) == 12, 32'(10 + i), 1);
        check_eq("basic_nbeats", obs.size(), 4);
        for (int k = 0; k < 4 && k < obs.size(); k++)
            check_eq("basic_beat", obs[k], {k == 3, 32'(15 + k)});
        check_eq("basic_frames", frame_count, 32'd1);
        check_eq("basic_search", state, 3'd1);

        // Backpressure with a 4-deep FIFO.
        do_reset();
        align_offset = 0; payload_len = 6; holdoff_len = 0;
        obs.delete();
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(1, 1, i == 0, 32'(100 + i), 0);
        check_eq("bp_drops", drop_count, 32'd2);
        check_eq("bp_valid", m00_axis_tvalid, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 1);
        check_eq("bp_nbeats", obs.size(), 4);
        if (obs.size() == 4) begin
            check_eq("bp_first", obs[0], {1'b0, 32'd101});
            check_eq("bp_third", obs[2], {1'b0, 32'd103});
            check_eq("bp_last", obs[3], {1'b1, 32'd106});
        end

        // Enable dropped during ALIGN aborts the frame.
        do_reset();
        align_offset = 3; payload_len = 2; holdoff_len = 0;
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 1, 1, 1);
        cycle(1, 1, 0, 2, 1);
        cycle(0, 1, 0, 3, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 32'(4 + i), 1);
        check_eq("align_abort_state", state, 3'd0);
        check_eq("align_abort_frames", frame_count, 32'd0);

        // Enable dropped during CAPTURE lets the frame complete.
        align_offset = 0; payload_len = 4;
        obs.delete();
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 1, 199, 1);
        cycle(1, 1, 0, 200, 1);
        for (int i = 1; i < 4; i++) cycle(0, 1, 0, 32'(200 + i), 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
        check_eq("cap_en_frames", frame_count, 32'd1);
        check_eq("cap_en_state", state, 3'd0);
        check_eq("cap_en_nbeats", obs.size(), 4);
        if (obs.size() == 4) check_eq("cap_en_last", obs[3], {1'b1, 32'd203});

        // Reset with two beats sitting in the FIFO, then a zero-length frame with input gaps.
        payload_len = 5;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 0, 1, 0);
        cycle(1, 1, 0, 2, 0);
        check_eq("pre_rst_valid", m00_axis_tvalid, 1'b1);
        do_reset();
        payload_len = 0;
        obs.delete();
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 1, 299, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 0, 300, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        check_eq("len0_frames", frame_count, 32'd1);
        check_eq("len0_nbeats", obs.size(), 1);
        if (obs.size() == 1) check_eq("len0_beat", obs[0], {1'b1, 32'd300});

        // Randomized traffic against the model, with a mid-run asynchronous reset.
        rp = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) rp = (c % 1500 == 0) ? 10 : ((c % 1000 == 0) ? 90 : 50);
            if (c == 1500) do_reset();
            align_offset = LW'($urandom_range(0, 3));
            payload_len  = LW'($urandom_range(0, 6));
            holdoff_len  = LW'($urandom_range(0, 3));
            cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 99) < rp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
